// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 8-bit ALU: issue, wait, capture into a FWFT response FIFO.
// Optional ALU_SEQ_CHECK_EN adds chk_err, an expected-result check on y and parity.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [1:0]             cmd_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [1:0]             alu_op,
    output logic                   alu_oe,
    input  logic [WIDTH-1:0]       alu_y,
    input  logic [4:0]             alu_flags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_y,
    output logic [4:0]             rsp_flags,
    output logic [1:0]             rsp_op,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
`ifdef ALU_SEQ_CHECK_EN
    ,
    output logic                   chk_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mem_y  [DEPTH];
    logic [4:0]       mem_f  [DEPTH];
    logic [1:0]       mem_op [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             accept;
    logic             push;
    logic             pop;

    // A slot is reserved at accept: only one op is ever in flight, and only from IDLE.
    assign full      = (level == LW'(DEPTH));
    assign cmd_ready = !rst && (state == IDLE) && !full;
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == WAIT) && (cnt == 4'd0);
    assign rsp_valid = (level != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (state != IDLE);

    assign rsp_y     = rsp_valid ? mem_y[rptr]  : '0;
    assign rsp_flags = rsp_valid ? mem_f[rptr]  : '0;
    assign rsp_op    = rsp_valid ? mem_op[rptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            alu_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= cmd_a;
                        alu_b  <= cmd_b;
                        alu_op <= cmd_op;
                        alu_oe <= 1'b1;
                        cnt    <= 4'(LAT - 1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        alu_oe <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_y[wptr]  <= alu_y;
            mem_f[wptr]  <= alu_flags;
            mem_op[wptr] <= alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_y;

    always_comb begin
        exp_y = '0;
        case (alu_op)
            2'b00:   exp_y = alu_a + alu_b;
            2'b01:   exp_y = alu_a - alu_b;
            2'b10:   exp_y = alu_a & alu_b;
            default: exp_y = alu_a ^ alu_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) chk_err <= 1'b0;
        else     chk_err <= push && ((exp_y != alu_y) ||
                                     ((^exp_y) != alu_flags[0]));
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and table-driven bench for alu_op_sequencer (LAT=1 and LAT=4 instances).
// Honours ALU_SEQ_CHECK_EN when defined.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       force_bad;
    int         n_chk = 0;
    int         n_err = 0;
    int         chk_cnt = 0;

    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [1:0] cmd_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [1:0] alu_op;
    logic       alu_oe;
    logic [4:0] alu_flags;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_y;
    logic [4:0] rsp_flags;
    logic [1:0] rsp_op;
    logic       busy;
    logic [2:0] level;
    logic       chk_err;

    logic       c4_valid, c4_ready;
    logic [7:0] c4_a, c4_b;
    logic [1:0] c4_op;
    logic [7:0] a4_a, a4_b, a4_y;
    logic [1:0] a4_op;
    logic       a4_oe;
    logic [4:0] a4_flags;
    logic       r4_valid, r4_ready;
    logic [7:0] r4_y;
    logic [4:0] r4_flags;
    logic [1:0] r4_op;
    logic       busy4;
    logic [2:0] level4;

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_y(input logic [1:0] op,
                                         input logic [7:0] a, b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [4:0] ref_flags(input logic [1:0] op,
                                             input logic [7:0] a, b, y);
        logic ov;
        ov = 1'b0;
        if (op == 2'b00) ov = (a[7] == b[7]) && (y[7] != a[7]);
        if (op == 2'b01) ov = (a[7] != b[7]) && (y[7] != a[7]);
        return {a < b, a == b, a > b, ov, ^y};
    endfunction

    // Golden ALU, with an injectable wrong answer for ADD 1+1
    always_comb begin
        alu_y = ref_y(alu_op, alu_a, alu_b);
        if (force_bad && alu_op == 2'b00 && alu_a == 8'h01 && alu_b == 8'h01)
            alu_y = 8'h00;
        alu_flags = ref_flags(alu_op, alu_a, alu_b, alu_y);
    end

    always_comb begin
        a4_y     = ref_y(a4_op, a4_a, a4_b);
        a4_flags = ref_flags(a4_op, a4_a, a4_b, a4_y);
    end

`ifndef ALU_SEQ_CHECK_EN
    assign chk_err = 1'b0;
`endif

    alu_op_sequencer #(.WIDTH(8), .LAT(1), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_oe(alu_oe),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_op(rsp_op),
        .busy(busy), .level(level)
`ifdef ALU_SEQ_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    alu_op_sequencer #(.WIDTH(8), .LAT(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .cmd_valid(c4_valid), .cmd_ready(c4_ready),
        .cmd_a(c4_a), .cmd_b(c4_b), .cmd_op(c4_op),
        .alu_a(a4_a), .alu_b(a4_b), .alu_op(a4_op), .alu_oe(a4_oe),
        .alu_y(a4_y), .alu_flags(a4_flags),
        .rsp_valid(r4_valid), .rsp_ready(r4_ready),
        .rsp_y(r4_y), .rsp_flags(r4_flags), .rsp_op(r4_op),
        .busy(busy4), .level(level4)
`ifdef ALU_SEQ_CHECK_EN
        , .chk_err()
`endif
    );

    always @(negedge clk) if (chk_err === 1'b1) chk_cnt++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic send(input logic [1:0] op, input logic [7:0] a, b);
        logic acc;
        int   n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 20) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b0;
        check("accept", acc, 1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, b,
                          output logic [7:0] y, output logic [4:0] f,
                          output logic [1:0] o);
        logic got;
        int   n;
        send(op, a, b);
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk); got = rsp_valid; n++;
        end
        check("rsp_arrives", got, 1);
        y = rsp_y; f = rsp_flags; o = rsp_op;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       par;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] ry;
    logic [4:0] rf;
    logic [1:0] ro;
    logic [7:0] q [$];
    int         acc_cyc [$];
    int         idx, oe_cnt, base;
    logic       seen, acc;

    initial begin
        tbl[0] = '{2'b00, 8'h05, 8'h03, 8'h08, 1'b1};
        tbl[1] = '{2'b01, 8'h10, 8'h01, 8'h0F, 1'b0};
        tbl[2] = '{2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[3] = '{2'b11, 8'hAA, 8'hFF, 8'h55, 1'b0};
        tbl[4] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b0};
        tbl[5] = '{2'b01, 8'h00, 8'h01, 8'hFF, 1'b0};
        tbl[6] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b1};
        tbl[7] = '{2'b11, 8'h0F, 8'h01, 8'h0E, 1'b1};
        tbl[8] = '{2'b10, 8'hFF, 8'h81, 8'h81, 1'b0};

        rst = 1'b1; force_bad = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        rsp_ready = 1'b0;
        c4_valid = 1'b0; c4_a = '0; c4_b = '0; c4_op = '0;
        r4_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_alu_oe", alu_oe, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single ADD: cycle-exact timing
        cmd_op = 2'b00; cmd_a = 8'h05; cmd_b = 8'h03; cmd_valid = 1'b1;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("wait_oe", alu_oe, 1);
        check("wait_busy", busy, 1);
        check("wait_ready", cmd_ready, 0);
        check("wait_rsp_valid", rsp_valid, 0);
        check("wait_alu_a", alu_a, 8'h05);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_oe", alu_oe, 0);
        check("done_ready", cmd_ready, 0);
        check("done_rsp_valid", rsp_valid, 1);
        check("add_y", rsp_y, 8'h08);
        check("add_par", rsp_flags[0], 1);
        check("add_op", rsp_op, 0);
        check("done_level", level, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("back_idle", busy, 0);
        check("idle_ready2", cmd_ready, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("pop_level", level, 0);
        @(posedge clk); #1;

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, ry, rf, ro);
            check($sformatf("tbl%0d_y", i), ry, tbl[i].y);
            check($sformatf("tbl%0d_par", i), rf[0], tbl[i].par);
            check($sformatf("tbl%0d_op", i), ro, tbl[i].op);
        end

        // Back-to-back commands with the consumer always ready
        q = {}; acc_cyc = {};
        idx = 1; rsp_ready = 1'b1;
        cmd_op = tbl[1].op; cmd_a = tbl[1].a; cmd_b = tbl[1].b;
        cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            if (rsp_valid) q.push_back(rsp_y);
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(c);
                idx++;
                if (idx > 3) cmd_valid = 1'b0;
                else begin
                    cmd_op = tbl[idx].op;
                    cmd_a  = tbl[idx].a;
                    cmd_b  = tbl[idx].b;
                end
            end
        end
        rsp_ready = 1'b0;
        check("b2b_accepts", acc_cyc.size(), 3);
        check("b2b_rsps", q.size(), 3);
        if (acc_cyc.size() == 3) begin
            check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 3);
            check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 3);
        end
        if (q.size() == 3) begin
            check("b2b_r0", q[0], 8'h0F);
            check("b2b_r1", q[1], 8'h30);
            check("b2b_r2", q[2], 8'h55);
        end

        // Fill the FIFO: DEPTH+1 commands, consumer stalled
        acc_cyc = {};
        idx = 0;
        cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h10; cmd_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(c);
                idx++;
                cmd_a = 8'(idx);
            end
        end
        @(negedge clk);
        check("full_accepts", acc_cyc.size(), 4);
        check("full_level", level, 4);
        check("full_ready", cmd_ready, 0);
        check("full_head", rsp_y, 8'h10);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("refill_accept", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        q = {};
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) q.push_back(rsp_y);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        check("wrap_count", q.size(), 4);
        for (int i = 0; i < 4 && i < q.size(); i++)
            check($sformatf("wrap_r%0d", i), q[i], 8'(8'h11 + i));

        // Push and pop on the same edge at level 2
        send(2'b00, 8'h01, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        send(2'b00, 8'h02, 8'h02);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("pp_level_pre", level, 2);
        @(posedge clk); #1;
        send(2'b00, 8'h03, 8'h03);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("pp_head_pre", rsp_y, 8'h02);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("pp_level", level, 2);
        check("pp_head", rsp_y, 8'h04);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pp_tail", rsp_y, 8'h06);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("pp_drained", level, 0);
        @(posedge clk); #1;

        // LAT=4: oe width, then reset during WAIT
        c4_op = 2'b00; c4_a = 8'h02; c4_b = 8'h03; c4_valid = 1'b1;
        @(negedge clk);
        check("l4_ready", c4_ready, 1);
        @(posedge clk); #1;
        c4_valid = 1'b0;
        oe_cnt = 0; seen = 1'b0; ry = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a4_oe) oe_cnt++;
            if (r4_valid && !seen) begin
                seen = 1'b1;
                ry = r4_y;
            end
        end
        check("l4_oe_cycles", oe_cnt, 4);
        check("l4_y", ry, 8'h05);
        check("l4_level", level4, 1);
        @(posedge clk); #1;
        c4_a = 8'h06; c4_b = 8'h07; c4_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        c4_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("l4_in_wait", a4_oe, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("l4_rst_oe", a4_oe, 0);
        check("l4_rst_busy", busy4, 0);
        check("l4_rst_level", level4, 0);
        check("l4_rst_valid", r4_valid, 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("l4_no_late_push", level4, 0);
        check("l4_no_late_valid", r4_valid, 0);
        @(posedge clk); #1;

`ifdef ALU_SEQ_CHECK_EN
        // Wrong ALU answer must raise chk_err for a single cycle
        base = chk_cnt;
        force_bad = 1'b1;
        run_op(2'b00, 8'h01, 8'h01, ry, rf, ro);
        repeat (3) @(posedge clk);
        #1;
        force_bad = 1'b0;
        check("bad_y", ry, 8'h00);
        check("chk_err_pulse", chk_cnt - base, 1);
        base = chk_cnt;
`else
        base = chk_cnt;
`endif

        // Random ops against the bench model
        for (int i = 0; i < 1000; i++) begin
            logic [1:0] op;
            logic [7:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            run_op(op, a, b, ry, rf, ro);
            check("rand_y", ry, ref_y(op, a, b));
        end
        repeat (2) @(posedge clk);
        #1;
        check("chk_err_quiet", chk_cnt - base, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
